symml_eval_arbiter: RTL

Round-robin arbiter and sequencer that shares one combinational 9-input symmetric evaluator (out = 1 iff popcount(in) is 3..6) among NREQ requesters. The block accepts 9-bit vectors over per-requester valid/ready handshakes, registers the winning vector onto the evaluator inputs, and captures the result. It returns the result tagged with the requester ID. It sits between the power-analysis stimulus sources and the evaluator instance, and keeps evaluator inputs stable between issues to minimise switching.

---
 rtl/symml_eval_arbiter.sv | 111 +++++++++++
 1 files changed

// File: rtl/symml_eval_arbiter.sv
// Round-robin arbiter that time-shares one 9-input symmetric evaluator among NREQ requesters.
// Optional SYMML_STATS_EN adds saturating eval_count/hit_count outputs.
module symml_eval_arbiter #(
    parameter int NREQ = 4,
    parameter int IDW  = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [NREQ-1:0]   req_valid,
    input  logic [9*NREQ-1:0] req_vec,
    output logic [NREQ-1:0]   req_ready,
    output logic [8:0]        eval_vec,
    input  logic              eval_hit,
    output logic              rsp_valid,
    output logic [IDW-1:0]    rsp_id,
    output logic              rsp_hit,
    input  logic              rsp_ready,
`ifdef SYMML_STATS_EN
    output logic [15:0]       eval_count,
    output logic [15:0]       hit_count,
`endif
    output logic              busy
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EVAL = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t         state;
    logic [IDW-1:0] last_grant;
    logic [IDW-1:0] grant_idx;
    logic           grant_any;
    int             idx;

    // Search starts one past the previous winner so every holder is reached within NREQ issues.
    always_comb begin
        // NOTE: every comb output gets a default first so no path leaves it unassigned (no latch).
        grant_idx = '0;
        grant_any = 1'b0;
        idx       = 0;
        for (int k = 1; k <= NREQ; k++) begin
            idx = (int'(last_grant) + k) % NREQ;
            if (!grant_any && req_valid[idx]) begin
                grant_any = 1'b1;
                grant_idx = IDW'(idx);
            end
        end
    end

    always_comb begin
        req_ready = '0;
        if (state == IDLE && !rst && grant_any)
            req_ready[grant_idx] = 1'b1;
    end

    // NOTE: all state below uses non-blocking assignment so every register sees pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            last_grant <= IDW'(NREQ - 1);
            eval_vec   <= '0;
            rsp_valid  <= 1'b0;
            rsp_id     <= '0;
            rsp_hit    <= 1'b0;
            busy       <= 1'b0;
`ifdef SYMML_STATS_EN
            eval_count <= '0;
            hit_count  <= '0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    // eval_vec is deliberately held when idle to avoid evaluator toggling.
                    if (grant_any) begin
                        eval_vec   <= req_vec[int'(grant_idx)*9 +: 9];
                        rsp_id     <= grant_idx;
                        last_grant <= grant_idx;
                        busy       <= 1'b1;
                        state      <= EVAL;
                    end
                end
                EVAL: begin
                    rsp_hit   <= eval_hit;
                    rsp_valid <= 1'b1;
                    state     <= RESP;
`ifdef SYMML_STATS_EN
                    if (eval_count != 16'hFFFF)
                        eval_count <= eval_count + 16'd1;
                    if (eval_hit && hit_count != 16'hFFFF)
                        hit_count <= hit_count + 16'd1;
`endif
                end
                RESP: begin
                    if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                        busy      <= 1'b0;
                        state     <= IDLE;
                    end
                end
                default: begin
                    rsp_valid <= 1'b0;
                    busy      <= 1'b0;
                    state     <= IDLE;
                end
            endcase
        end
    end

endmodule
